mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
Iterative multiply/divide unit with architectural HI/LO registers. It adds MULT/MULTU/DIV/DIVU/MTHI/MTLO support to the 5-stage pipeline. It sits in EX beside the ALU and takes forwarded rs/rt operands. It raises a stall request to the hazard unit while busy and a dependent MFHI/MFLO or a new mul/div op is in EX. Width and multiply mode are parametrised.

Parameters:
WIDTH, 32, operand/HI/LO width (>=4, even)
FAST_MUL, 0, 1 = single-cycle registered multiply; 0 = iterative shift-add multiply

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  launch op in EX; accepted only in IDLE without flush
op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 no-op
in_a  in  WIDTH  rs operand (dividend / multiplicand / MT source)
in_b  in  WIDTH  rt operand (divisor / multiplier)
flush  in  1  kill in-flight op
rd_req  in  1  MFHI/MFLO currently in EX
busy  out  1  op in progress
done  out  1  one-cycle pulse, HI/LO just updated by mul/div
stall_req  out  1  combinational: busy & (start | rd_req)
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- One clock (clk); reset is synchronous and active-high. Reset (incl. mid-op) -> state IDLE, hi=lo=0, busy=0, done=0, counter=0.
- FSM states:
  - IDLE -> RUN on accepted MULT/MULTU/DIV/DIVU.
  - RUN runs WIDTH iterations, then -> FIXUP.
  - FIXUP writes HI/LO, pulses done, -> IDLE.
- Latency: acceptance edge E0; iterations E1..E_WIDTH; FIXUP edge E_WIDTH+1 updates hi/lo and sets done for one cycle. busy is high for WIDTH+1 cycles after E0 and falls together with done rising.
- FAST_MUL=1: MULT/MULTU write hi/lo at E1, done at E1, busy high for one cycle. Divide is always iterative.
- MTHI/MTLO: write hi (or lo) = in_a at E0. No busy, no done, other register unchanged.
- Signed ops:
  - Iterate on magnitudes; |MIN| is treated as unsigned 2^(WIDTH-1).
  - Product negated iff operand signs differ.
  - Quotient negated iff signs differ; remainder takes the dividend's sign.
- Results:
  - Multiply: {hi,lo} = full 2*WIDTH product.
  - Divide: lo = quotient, hi = remainder.
- Divide by zero: still full latency; hi = in_a as latched, lo = all ones (signed and unsigned). No exception.
- Overflow MIN / -1 (signed): lo = MIN, hi = 0.
- Operands are latched at E0; later changes on in_a/in_b are ignored.
- start while busy: ignored, not queued; stall_req holds the pipeline so EX re-presents the op later.
- flush: any state -> IDLE on next edge. hi/lo unchanged, no done. flush with start in the same cycle: flush wins, start dropped. flush in FIXUP cycle: result discarded.
- done and a new start may coincide: the start in the done cycle is accepted (busy already low).
- op 6-7 with start: ignored.

Decomposition:
- Package md_pkg: op encodings (MD_MULT..MD_MTLO), FSM state enum (IDLE/RUN/FIXUP), counter width constant clog2(WIDTH+1).
- Sub-module md_shift_core: shared 2*WIDTH-bit shift register plus WIDTH+1-bit adder/subtractor. Performs one shift-add (mul) or restoring subtract step (div) per cycle.
- Top level holds the FSM, sign capture/fixup, HI/LO and stall logic.

Test Plan:
1. WIDTH=32, MULT a=0xFFFFFFFD b=7 -> after 33 cycles hi=0xFFFFFFFF lo=0xFFFFFFEB; done high exactly 1 cycle; busy high 33 cycles.
2. MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001. Rerun with FAST_MUL=1 -> same result at E1, busy 1 cycle.
3. DIV 0xFFFFFFF9 / 2 (-7/2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7 / 0 -> hi=7, lo=0xFFFFFFFF.
4. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 100 / 7 -> lo=14, hi=2.
5. DIVU start, flush at cycle 10 -> busy 0 next cycle, no done, hi/lo keep prior values. start+flush same cycle -> nothing accepted. start with rd_req while busy -> stall_req=1, op not accepted.
6. Assert reset at cycle 5 of MULT -> hi=lo=0, busy=done=0 next cycle. MTHI 0x1234 then MTLO 0x5678 -> hi=0x1234, lo=0x5678, no done, no stall.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and the iteration-counter width helper.
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2
  } md_state_e;

  // The counter must hold 0..WIDTH, hence clog2(WIDTH+1) bits.
  function automatic int md_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/md_shift_core.sv
// Shared 2*WIDTH shift register plus one WIDTH+1-bit adder: a shift-add
// multiply step or a restoring divide step per cycle on unsigned magnitudes.
module md_shift_core
  import md_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               is_div_i,
  input  logic [WIDTH-1:0]   load_lo_i,
  input  logic [WIDTH-1:0]   load_m_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic [2*WIDTH-1:0] prod_o
);

  logic [2*WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   hi_part, lo_part;
  logic [WIDTH:0]     add_x, add_y;
  logic               add_cin;
  logic [WIDTH+1:0]   add_full;
  logic               ge;

  assign hi_part = shreg_q[2*WIDTH-1:WIDTH];
  assign lo_part = shreg_q[WIDTH-1:0];

  // Divide subtracts via x + ~y + 1; the carry out is the "no borrow" flag.
  always_comb begin
    add_x   = {1'b0, hi_part};
    add_y   = '0;
    add_cin = 1'b0;
    if (is_div_i) begin
      add_x   = {hi_part, lo_part[WIDTH-1]};
      add_y   = ~{1'b0, mcand_q};
      add_cin = 1'b1;
    end else if (lo_part[0]) begin
      add_y = {1'b0, mcand_q};
    end
  end

  assign add_full = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, add_cin};
  assign ge       = add_full[WIDTH+1];

  always_comb begin
    shreg_d = shreg_q;
    mcand_d = mcand_q;
    if (load_i) begin
      shreg_d = {{WIDTH{1'b0}}, load_lo_i};
      mcand_d = load_m_i;
    end else if (step_i) begin
      if (is_div_i)
        shreg_d = {(ge ? add_full[WIDTH-1:0] : add_x[WIDTH-1:0]),
                   lo_part[WIDTH-2:0], ge};
      else
        shreg_d = {add_full[WIDTH:0], lo_part[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
      mcand_q <= '0;
    end else begin
      shreg_q <= shreg_d;
      mcand_q <= mcand_d;
    end
  end

  assign acc_o = shreg_q;

  generate
    if (FAST_MUL) begin : g_fast
      assign prod_o = {{WIDTH{1'b0}}, mcand_q} * {{WIDTH{1'b0}}, lo_part};
    end else begin : g_iter
      assign prod_o = shreg_q;
    end
  endgenerate

endmodule

// File: rtl/mul_div_unit.sv
// EX-stage multiply/divide unit with HI/LO: FSM, sign handling around the
// magnitude core, HI/LO writeback and the hazard-unit stall request.
module mul_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             flush,
  input  logic             rd_req,
  output logic             busy,
  output logic             done,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = md_cnt_w(WIDTH);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, araw_q, araw_d;
  logic               done_q, done_d;
  logic               isdiv_q, isdiv_d, neg_q, neg_d, remneg_q, remneg_d;
  logic               divz_q, divz_d;

  logic               signed_op, is_mul_op, is_div_op, accept;
  logic               sa, sb;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] acc, prod_mag, prod_res;
  logic [WIDTH-1:0]   quo, rem, quo_res, rem_res;

  assign signed_op = (op == MD_MULT) || (op == MD_DIV);
  assign is_mul_op = (op == MD_MULT) || (op == MD_MULTU);
  assign is_div_op = (op == MD_DIV)  || (op == MD_DIVU);
  assign accept    = start && !flush && (state_q == IDLE);

  // Magnitudes: negating MIN yields 2^(WIDTH-1) read as unsigned.
  assign sa    = signed_op & in_a[WIDTH-1];
  assign sb    = signed_op & in_b[WIDTH-1];
  assign a_mag = sa ? -in_a : in_a;
  assign b_mag = sb ? -in_b : in_b;

  md_shift_core #(
    .WIDTH    (WIDTH),
    .FAST_MUL (FAST_MUL)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .load_i    (accept && (is_mul_op || is_div_op)),
    .step_i    (state_q == RUN),
    .is_div_i  (isdiv_q),
    .load_lo_i (is_div_op ? a_mag : b_mag),
    .load_m_i  (is_div_op ? b_mag : a_mag),
    .acc_o     (acc),
    .prod_o    (prod_mag)
  );

  assign prod_res = neg_q ? -prod_mag : prod_mag;
  assign quo      = acc[WIDTH-1:0];
  assign rem      = acc[2*WIDTH-1:WIDTH];
  assign quo_res  = neg_q ? -quo : quo;
  assign rem_res  = remneg_q ? -rem : rem;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    isdiv_d  = isdiv_q;
    neg_d    = neg_q;
    remneg_d = remneg_q;
    divz_d   = divz_q;
    araw_d   = araw_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mul_op || is_div_op) begin
            isdiv_d  = is_div_op;
            neg_d    = sa ^ sb;
            remneg_d = sa;
            divz_d   = is_div_op && (in_b == '0);
            araw_d   = in_a;
            cnt_d    = '0;
            state_d  = (FAST_MUL && is_mul_op) ? FIXUP : RUN;
          end else if (op == MD_MTHI) begin
            hi_d = in_a;
          end else if (op == MD_MTLO) begin
            lo_d = in_a;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = FIXUP;
        end
      end
      FIXUP: begin
        if (!isdiv_q) begin
          hi_d = prod_res[2*WIDTH-1:WIDTH];
          lo_d = prod_res[WIDTH-1:0];
        end else if (divz_q) begin
          hi_d = araw_q;
          lo_d = '1;
        end else begin
          hi_d = rem_res;
          lo_d = quo_res;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Flush kills whatever is in flight, including a finished-but-unwritten result.
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      isdiv_q  <= 1'b0;
      neg_q    <= 1'b0;
      remneg_q <= 1'b0;
      divz_q   <= 1'b0;
      araw_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      isdiv_q  <= isdiv_d;
      neg_q    <= neg_d;
      remneg_q <= remneg_d;
      divz_q   <= divz_d;
      araw_q   <= araw_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign stall_req = busy && (start || rd_req);
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: an iterative instance and a
// FAST_MUL instance, with hand-computed HI/LO expectations.
module tb_mul_div_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, startFast, flush, rd_req;
  logic [2:0]  op;
  logic [31:0] in_a, in_b;
  logic        busy, done, stall_req, fBusy, fDone, fStall;
  logic [31:0] hi, lo, fHi, fLo;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;
  vec_t vecs[9];

  mul_div_unit #(.WIDTH(32), .FAST_MUL(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .in_a(in_a), .in_b(in_b),
    .flush(flush), .rd_req(rd_req), .busy(busy), .done(done),
    .stall_req(stall_req), .hi(hi), .lo(lo)
  );

  mul_div_unit #(.WIDTH(32), .FAST_MUL(1'b1)) dutFast (
    .clk(clk), .reset(reset), .start(startFast), .op(op), .in_a(in_a), .in_b(in_b),
    .flush(flush), .rd_req(rd_req), .busy(fBusy), .done(fDone),
    .stall_req(fStall), .hi(fHi), .lo(fLo)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; returns at the negedge after the acceptance edge,
  // with the operands scrambled to prove they were latched.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a,
                               input logic [31:0] b);
    op = o; in_a = a; in_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_a = $urandom; in_b = $urandom;
  endtask

  task automatic waitDone(output int busyCycles);
    int n = 0;
    busyCycles = 0;
    while (!done && n < 100) begin
      if (busy) busyCycles++;
      @(negedge clk);
      n++;
    end
    if (!done) checkOutput("done_timeout", {63'd0, done}, 64'd1);
  endtask

  initial begin
    int bc;
    bit doneSeen;
    reset = 1'b1; start = 1'b0; startFast = 1'b0; flush = 1'b0; rd_req = 1'b0;
    op = '0; in_a = '0; in_b = '0;
    vecs[0] = '{MD_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[3] = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[5] = '{MD_DIVU,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF};
    vecs[6] = '{MD_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[7] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[8] = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_hi",    {32'd0, hi}, 64'd0);
    checkOutput("rst_lo",    {32'd0, lo}, 64'd0);
    checkOutput("rst_busy",  {63'd0, busy}, 64'd0);
    checkOutput("rst_done",  {63'd0, done}, 64'd0);
    checkOutput("rst_stall", {63'd0, stall_req}, 64'd0);

    // Iterative mul/div vectors: result, busy length, one-cycle done.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      waitDone(bc);
      checkOutput($sformatf("v%0d_hi", i), {32'd0, hi}, {32'd0, vecs[i].hi});
      checkOutput($sformatf("v%0d_lo", i), {32'd0, lo}, {32'd0, vecs[i].lo});
      checkOutput($sformatf("v%0d_busy_cycles", i), 64'(bc), 64'd33);
      checkOutput($sformatf("v%0d_busy_at_done", i), {63'd0, busy}, 64'd0);
      @(negedge clk);
      checkOutput($sformatf("v%0d_done_width", i), {63'd0, done}, 64'd0);
    end

    // Single-cycle multiply instance.
    op = MD_MULTU; in_a = 32'hFFFFFFFF; in_b = 32'hFFFFFFFF; startFast = 1'b1;
    @(negedge clk);
    startFast = 1'b0; in_a = '0; in_b = '0;
    checkOutput("fast_busy_e0", {63'd0, fBusy}, 64'd1);
    checkOutput("fast_done_e0", {63'd0, fDone}, 64'd0);
    @(negedge clk);
    checkOutput("fast_done_e1", {63'd0, fDone}, 64'd1);
    checkOutput("fast_busy_e1", {63'd0, fBusy}, 64'd0);
    checkOutput("fast_prod", {fHi, fLo}, 64'hFFFFFFFE_00000001);
    @(negedge clk);
    checkOutput("fast_done_width", {63'd0, fDone}, 64'd0);

    // Stall while busy; a start during busy must not be queued.
    applyStimulus(MD_DIVU, 32'd1000, 32'd7);
    rd_req = 1'b1;
    #1 checkOutput("stall_rd", {63'd0, stall_req}, 64'd1);
    rd_req = 1'b0; start = 1'b1; op = MD_MULT; in_a = 32'd3; in_b = 32'd5;
    #1 checkOutput("stall_start", {63'd0, stall_req}, 64'd1);
    @(negedge clk);
    start = 1'b0;
    waitDone(bc);
    checkOutput("busy_start_hi", {32'd0, hi}, 64'd6);
    checkOutput("busy_start_lo", {32'd0, lo}, 64'd142);
    @(negedge clk);
    checkOutput("not_queued", {63'd0, busy}, 64'd0);
    rd_req = 1'b1;
    #1 checkOutput("stall_idle_rd", {63'd0, stall_req}, 64'd0);
    rd_req = 1'b0;

    // A start in the done cycle is accepted.
    applyStimulus(MD_MULTU, 32'd6, 32'd7);
    waitDone(bc);
    checkOutput("b2b_first_lo", {32'd0, lo}, 64'd42);
    applyStimulus(MD_MULTU, 32'd9, 32'd9);
    checkOutput("b2b_accepted", {63'd0, busy}, 64'd1);
    waitDone(bc);
    checkOutput("b2b_second", {hi, lo}, 64'd81);

    // Flush mid-divide: no done, HI/LO untouched.
    applyStimulus(MD_DIVU, 32'd50, 32'd3);
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_busy", {63'd0, busy}, 64'd0);
    doneSeen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) doneSeen = 1'b1;
    end
    checkOutput("flush_no_done", {63'd0, doneSeen}, 64'd0);
    checkOutput("flush_hilo", {hi, lo}, 64'd81);

    // Start together with flush is dropped.
    flush = 1'b1;
    applyStimulus(MD_DIVU, 32'd9, 32'd3);
    checkOutput("startflush_busy", {63'd0, busy}, 64'd0);
    applyStimulus(MD_MTHI, 32'hFFFF, 32'd0);
    flush = 1'b0;
    checkOutput("startflush_mthi", {hi, lo}, 64'd81);

    // MTHI / MTLO.
    op = MD_MTHI; in_a = 32'h1234; start = 1'b1;
    #1 checkOutput("mthi_stall", {63'd0, stall_req}, 64'd0);
    applyStimulus(MD_MTHI, 32'h1234, 32'd0);
    checkOutput("mthi_busy", {63'd0, busy}, 64'd0);
    applyStimulus(MD_MTLO, 32'h5678, 32'd0);
    checkOutput("mtlo_done", {63'd0, done}, 64'd0);
    checkOutput("mt_hilo", {hi, lo}, {32'h1234, 32'h5678});

    // Reserved op codes are ignored.
    applyStimulus(3'd6, 32'hAAAA, 32'hBBBB);
    checkOutput("op6_busy", {63'd0, busy}, 64'd0);
    checkOutput("op6_hilo", {hi, lo}, {32'h1234, 32'h5678});

    // Reset during a multiply.
    applyStimulus(MD_MULT, 32'd3, 32'd5);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midrst_hilo", {hi, lo}, 64'd0);
    checkOutput("midrst_busy", {63'd0, busy}, 64'd0);
    checkOutput("midrst_done", {63'd0, done}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
